// File: rtl/dtc_inverse_scan.sv
// Inverse-query scanner: sweeps every classifier input and streams the vectors that map to a requested class.
// Optional DTC_INV_SCAN_ABORT_EN adds an abort input that cancels a running scan.
module dtc_inverse_scan #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned CLS_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CLS_W-1:0] req_cls,
  output logic [IN_W-1:0]  probe,
  input  logic [CLS_W-1:0] probe_cls,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IN_W-1:0]  out_vec,
  output logic             done,
`ifdef DTC_INV_SCAN_ABORT_EN
  input  logic             abort,
`endif
  output logic [IN_W:0]    match_cnt
);

  localparam int unsigned CNT_W = IN_W + 1;
  localparam logic [IN_W-1:0] PROBE_MAX = '1;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

  state_t           state, state_n;
  logic [CLS_W-1:0] target, target_n;
  logic [IN_W-1:0]  probe_n, out_vec_n;
  logic [CNT_W-1:0] match_cnt_n;
  logic             out_valid_n, done_n, req_ready_n;
  logic             abort_hit;

`ifdef DTC_INV_SCAN_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      target    <= '0;
      probe     <= '0;
      out_vec   <= '0;
      out_valid <= 1'b0;
      match_cnt <= '0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_n;
      target    <= target_n;
      probe     <= probe_n;
      out_vec   <= out_vec_n;
      out_valid <= out_valid_n;
      match_cnt <= match_cnt_n;
      done      <= done_n;
      req_ready <= req_ready_n;
    end
  end

  // Next-state and next-output logic; abort outranks a same-cycle match or handshake
  always_comb begin
    state_n     = state;
    target_n    = target;
    probe_n     = probe;
    out_vec_n   = out_vec;
    out_valid_n = out_valid;
    match_cnt_n = match_cnt;

    case (state)
      IDLE: begin
        if (req_valid) begin
          target_n    = req_cls;
          probe_n     = '0;
          match_cnt_n = '0;
          state_n     = SCAN;
        end
      end
      SCAN: begin
        if (abort_hit) begin
          state_n = IDLE;
        end else if (probe_cls == target) begin
          out_vec_n   = probe;
          out_valid_n = 1'b1;
          match_cnt_n = match_cnt + CNT_W'(1);
          state_n     = HOLD;
        end else if (probe == PROBE_MAX) begin
          state_n = DONE;
        end else begin
          probe_n = probe + IN_W'(1);
        end
      end
      HOLD: begin
        if (abort_hit) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end else if (out_ready) begin
          out_valid_n = 1'b0;
          if (probe == PROBE_MAX) begin
            state_n = DONE;
          end else begin
            probe_n = probe + IN_W'(1);
            state_n = SCAN;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    done_n      = (state_n == DONE);
    req_ready_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_dtc_inverse_scan.sv
// Directed bench for dtc_inverse_scan with a stub classifier selectable per test.
module tb_dtc_inverse_scan;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned CLS_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [CLS_W-1:0] req_cls;
  logic [IN_W-1:0]  probe;
  logic [CLS_W-1:0] probe_cls;
  logic             out_valid;
  logic             out_ready;
  logic [IN_W-1:0]  out_vec;
  logic             done;
  logic [IN_W:0]    match_cnt;
`ifdef DTC_INV_SCAN_ABORT_EN
  logic             abort;
`endif

  int checks = 0;
  int errors = 0;
  int mode   = 0;

  always #5 clk = ~clk;

  dtc_inverse_scan #(.IN_W(IN_W), .CLS_W(CLS_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cls   (req_cls),
    .probe     (probe),
    .probe_cls (probe_cls),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .done      (done),
`ifdef DTC_INV_SCAN_ABORT_EN
    .abort     (abort),
`endif
    .match_cnt (match_cnt)
  );

  // Stub classifiers: 0 -> low two bits, 1 -> constant 3, 2 -> constant 1
  always_comb begin
    case (mode)
      0:       probe_cls = probe[1:0];
      1:       probe_cls = 2'd3;
      default: probe_cls = 2'd1;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int model_cls(input int m, input int v);
    case (m)
      0:       return v % 4;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int next_match(input int m, input int cls, input int from);
    for (int v = from; v < 256; v++)
      if (model_cls(m, v) == cls) return v;
    return 256;
  endfunction

  function automatic int total_matches(input int m, input int cls);
    int t = 0;
    for (int v = 0; v < 256; v++)
      if (model_cls(m, v) == cls) t++;
    return t;
  endfunction

  // One full query; stall toggles out_ready 1-in-3, poke fires a stray request mid-scan,
  // abort_at > 0 cancels the scan while the abort_at-th match is held.
  task automatic run_scan(input int m, input int cls, input bit stall, input bit poke,
                          input int abort_at);
    int n = 0;
    int exp_vec;
    int emitted = 0;
    int stalls = 0;
    int lat = 0;
    int total;
    bit got_done = 1'b0;
    bit aborted = 1'b0;
    total = total_matches(m, cls);
    mode = m;
    exp_vec = next_match(m, cls, 0);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_cls   = CLS_W'(cls);
    out_ready = 1'b1;
    while (n < 2000 && !got_done && !aborted) begin
      @(negedge clk);
      n++;
      req_valid = 1'b0;
      if (n == 1) check("probe_start", 32'(probe), 32'd0);
      if (poke && n == 50) begin
        check("req_ready_busy", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_cls   = 2'd0;
      end
      if (done) begin
        got_done = 1'b1;
        lat = n;
        check("done_vs_valid", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        check("out_vec", 32'(out_vec), 32'(exp_vec));
`ifdef DTC_INV_SCAN_ABORT_EN
        if (abort_at > 0 && emitted + 1 == abort_at) begin
          check("cnt_at_abort", 32'(match_cnt), 32'(abort_at));
          abort     = 1'b1;
          out_ready = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check("abort_ready", 32'(req_ready), 32'd1);
          check("abort_valid", 32'(out_valid), 32'd0);
          check("abort_cnt", 32'(match_cnt), 32'(abort_at));
          check("abort_done", 32'(done), 32'd0);
          repeat (3) begin
            @(negedge clk);
            check("abort_quiet", 32'(done | out_valid), 32'd0);
          end
          aborted = 1'b1;
        end
`endif
        if (!aborted) begin
          out_ready = stall ? (n % 3 == 0) : 1'b1;
          if (out_ready) begin
            emitted++;
            exp_vec = next_match(m, cls, exp_vec + 1);
          end else begin
            stalls++;
          end
        end
      end
    end
    out_ready = 1'b1;
    if (aborted) return;
    check("done_seen", 32'(got_done), 32'd1);
    check("latency", 32'(lat), 32'(256 + total + 1 + stalls));
    check("emitted", 32'(emitted), 32'(total));
    check("match_cnt", 32'(match_cnt), 32'(total));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("req_ready_after", 32'(req_ready), 32'd1);
    check("match_cnt_hold", 32'(match_cnt), 32'(total));
  endtask

  initial begin
    int hs;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_cls   = '0;
    out_ready = 1'b1;
`ifdef DTC_INV_SCAN_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_probe", 32'(probe), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_vec", 32'(out_vec), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_match_cnt", 32'(match_cnt), 32'd0);
    rst_n = 1'b1;

    run_scan(0, 2, 1'b0, 1'b0, 0);
    run_scan(1, 0, 1'b0, 1'b0, 0);
    run_scan(2, 1, 1'b1, 1'b0, 0);
    run_scan(0, 2, 1'b0, 1'b1, 0);

    // Reset while holding the sixth match
    mode = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_cls   = 2'd2;
    out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 200 && hs < 6; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (out_valid) begin
        hs++;
        out_ready = (hs < 6);
      end
    end
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_cnt", 32'(match_cnt), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_probe", 32'(probe), 32'd0);
    check("async_rst_cnt", 32'(match_cnt), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'd0);
    run_scan(0, 2, 1'b0, 1'b0, 0);

`ifdef DTC_INV_SCAN_ABORT_EN
    run_scan(0, 2, 1'b0, 1'b0, 10);
    run_scan(0, 2, 1'b0, 1'b0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
